// File: rtl/uart_cmd_parser_if.sv
// Purpose: bundles the byte-stream handshakes and the decoded control/program
//          outputs of uart_cmd_parser into one interface.
// Signals: rx_data/rx_valid    received byte stream (no backpressure)
//          tx_data/tx_valid/tx_ready  one-byte 'K'/'E' acknowledge stream
//          cpuhalt/cpustart/cpustep/cpurst  one-cycle CPU control pulses
//          dvpage/pvpage       view page registers
//          progen/progaddr/progdata  program memory write strobe and payload
// Modports: slave = parser side, master = host/transmitter side.
interface uart_cmd_parser_if #(
    parameter int unsigned DVPBITS = 8,
    parameter int unsigned PVPBITS = 8,
    parameter int unsigned WORDW   = 32,
    parameter int unsigned ADDRW   = 20
);
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               cpuhalt;
    logic               cpustart;
    logic               cpustep;
    logic               cpurst;
    logic [DVPBITS-1:0] dvpage;
    logic [PVPBITS-1:0] pvpage;
    logic               progen;
    logic [ADDRW-1:0]   progaddr;
    logic [WORDW-1:0]   progdata;

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid,
        output cpuhalt, cpustart, cpustep, cpurst,
        output dvpage, pvpage,
        output progen, progaddr, progdata
    );

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid,
        input  cpuhalt, cpustart, cpustep, cpurst,
        input  dvpage, pvpage,
        input  progen, progaddr, progdata
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Purpose: decodes ASCII command packets from a received-byte stream into CPU
//          control pulses, view-page registers and program-memory writes, and
//          returns a 'K'/'E' acknowledge byte for every '\n'-terminated packet.
// Ports:   clk  rising-edge clock
//          rst  asynchronous active-high reset
//          bus  uart_cmd_parser_if.slave (rx stream in, ack stream and all
//               decoded outputs out; every output is registered)
module uart_cmd_parser #(
    parameter int unsigned DVPBITS = 8,
    parameter int unsigned PVPBITS = 8,
    parameter int unsigned WORDW   = 32,
    parameter int unsigned ADDRW   = 20
) (
    input  logic               clk,
    input  logic               rst,
    uart_cmd_parser_if.slave   bus
);

    localparam int unsigned MAXDIG = WORDW / 4;
    localparam int unsigned CNTW   = $clog2(MAXDIG + 1);

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_CM = 8'h2C;  // ','
    localparam logic [7:0] CH_LB = 8'h5B;  // '['
    localparam logic [7:0] CH_RB = 8'h5D;  // ']'
    localparam logic [7:0] CH_H  = 8'h48;
    localparam logic [7:0] CH_Z  = 8'h5A;
    localparam logic [7:0] CH_S  = 8'h53;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_V  = 8'h56;
    localparam logic [7:0] CH_A  = 8'h41;
    localparam logic [7:0] CH_P  = 8'h50;
    localparam logic [7:0] CH_K  = 8'h4B;
    localparam logic [7:0] CH_E  = 8'h45;

    typedef enum logic [3:0] {
        IDLE, END1, ARG0, ARG1, AARG, POPEN, PWORD, PEND, ERR
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [WORDW-1:0]   r_acc, w_acc_nxt;
    logic [CNTW-1:0]    r_ndig, w_ndig_nxt;
    logic [1:0]         r_cmd, w_cmd_nxt;
    logic               r_first, w_first_nxt;
    logic [DVPBITS-1:0] r_arg0, w_arg0_nxt;
    logic [ADDRW-1:0]   r_base, w_base_nxt;

    logic               r_halt, w_halt_nxt;
    logic               r_start, w_start_nxt;
    logic               r_step, w_step_nxt;
    logic               r_crst, w_crst_nxt;
    logic [DVPBITS-1:0] r_dvpage, w_dvpage_nxt;
    logic [PVPBITS-1:0] r_pvpage, w_pvpage_nxt;
    logic               r_progen, w_progen_nxt;
    logic [ADDRW-1:0]   r_progaddr, w_progaddr_nxt;
    logic [WORDW-1:0]   r_progdata, w_progdata_nxt;
    logic [7:0]         r_tx_data, w_tx_data_nxt;
    logic               r_tx_valid, w_tx_valid_nxt;

    logic               w_is_hex;
    logic [3:0]         w_nib;
    logic               w_full;
    logic               w_has_dig;
    logic [WORDW-1:0]   w_acc_shift;
    logic               w_ack;
    logic [7:0]         w_ack_char;

    // ASCII hex digit decode
    always_comb begin
        w_is_hex = 1'b1;
        w_nib    = 4'd0;
        if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39)
            w_nib = 4'(bus.rx_data - 8'h30);
        else if (bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46)
            w_nib = 4'(bus.rx_data - 8'h37);
        else if (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66)
            w_nib = 4'(bus.rx_data - 8'h57);
        else
            w_is_hex = 1'b0;
    end

    assign w_full      = (r_ndig == CNTW'(MAXDIG));
    assign w_has_dig   = (r_ndig != '0);
    assign w_acc_shift = WORDW'({r_acc, w_nib});

    // Next-state, datapath and output decode
    always_comb begin
        w_state_nxt    = r_state;
        w_acc_nxt      = r_acc;
        w_ndig_nxt     = r_ndig;
        w_cmd_nxt      = r_cmd;
        w_first_nxt    = r_first;
        w_arg0_nxt     = r_arg0;
        w_base_nxt     = r_base;
        w_halt_nxt     = 1'b0;
        w_start_nxt    = 1'b0;
        w_step_nxt     = 1'b0;
        w_crst_nxt     = 1'b0;
        w_dvpage_nxt   = r_dvpage;
        w_pvpage_nxt   = r_pvpage;
        w_progen_nxt   = 1'b0;
        w_progdata_nxt = r_progdata;
        // address advances the cycle after each write strobe
        w_progaddr_nxt = r_progaddr + ADDRW'(r_progen);
        w_ack          = 1'b0;
        w_ack_char     = CH_K;

        if (bus.rx_valid && bus.rx_data != CH_CR) begin
            // argument states share digit accumulation; overflow is an error
            if ((r_state == ARG0 || r_state == ARG1 || r_state == AARG ||
                 r_state == PWORD) && w_is_hex) begin
                if (w_full) begin
                    w_state_nxt = ERR;
                end else begin
                    w_acc_nxt   = w_acc_shift;
                    w_ndig_nxt  = r_ndig + CNTW'(1);
                    w_first_nxt = 1'b0;
                end
            end else if (r_state != IDLE && r_state != ERR && bus.rx_data == CH_LF &&
                         !(r_state == END1 || r_state == PEND ||
                           ((r_state == ARG1 || r_state == AARG) && w_has_dig))) begin
                // '\n' arriving where it does not complete a packet
                w_ack       = 1'b1;
                w_ack_char  = CH_E;
                w_state_nxt = IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        w_acc_nxt  = '0;
                        w_ndig_nxt = '0;
                        case (bus.rx_data)
                            CH_H: begin w_state_nxt = END1; w_cmd_nxt = 2'd0; end
                            CH_Z: begin w_state_nxt = END1; w_cmd_nxt = 2'd1; end
                            CH_S: begin w_state_nxt = END1; w_cmd_nxt = 2'd2; end
                            CH_R: begin w_state_nxt = END1; w_cmd_nxt = 2'd3; end
                            CH_V: w_state_nxt = ARG0;
                            CH_A: w_state_nxt = AARG;
                            CH_P: begin
                                w_state_nxt    = POPEN;
                                w_halt_nxt     = 1'b1;
                                w_progaddr_nxt = r_base;
                            end
                            CH_LF:   w_state_nxt = IDLE;
                            default: w_state_nxt = ERR;
                        endcase
                    end
                    END1: begin
                        if (bus.rx_data == CH_LF) begin
                            w_ack       = 1'b1;
                            w_state_nxt = IDLE;
                            case (r_cmd)
                                2'd0:    w_halt_nxt  = 1'b1;
                                2'd1:    w_start_nxt = 1'b1;
                                2'd2:    w_step_nxt  = 1'b1;
                                default: w_crst_nxt  = 1'b1;
                            endcase
                        end else begin
                            w_state_nxt = ERR;
                        end
                    end
                    ARG0: begin
                        if (bus.rx_data == CH_CM && w_has_dig) begin
                            w_arg0_nxt  = DVPBITS'(r_acc);
                            w_acc_nxt   = '0;
                            w_ndig_nxt  = '0;
                            w_state_nxt = ARG1;
                        end else begin
                            w_state_nxt = ERR;
                        end
                    end
                    ARG1: begin
                        if (bus.rx_data == CH_LF) begin
                            w_dvpage_nxt = r_arg0;
                            w_pvpage_nxt = PVPBITS'(r_acc);
                            w_ack        = 1'b1;
                            w_state_nxt  = IDLE;
                        end else begin
                            w_state_nxt = ERR;
                        end
                    end
                    AARG: begin
                        if (bus.rx_data == CH_LF) begin
                            w_base_nxt  = ADDRW'(r_acc);
                            w_ack       = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = ERR;
                        end
                    end
                    POPEN: begin
                        if (bus.rx_data == CH_LB) begin
                            w_acc_nxt   = '0;
                            w_ndig_nxt  = '0;
                            w_first_nxt = 1'b1;
                            w_state_nxt = PWORD;
                        end else begin
                            w_state_nxt = ERR;
                        end
                    end
                    PWORD: begin
                        if ((bus.rx_data == CH_CM || bus.rx_data == CH_RB) && w_has_dig) begin
                            w_progen_nxt   = 1'b1;
                            w_progdata_nxt = r_acc;
                            w_acc_nxt      = '0;
                            w_ndig_nxt     = '0;
                            w_first_nxt    = 1'b0;
                            w_state_nxt    = (bus.rx_data == CH_RB) ? PEND : PWORD;
                        end else if (bus.rx_data == CH_RB && r_first) begin
                            // "[]" is a legal empty list
                            w_state_nxt = PEND;
                        end else begin
                            w_state_nxt = ERR;
                        end
                    end
                    PEND: begin
                        if (bus.rx_data == CH_LF) begin
                            w_ack       = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = ERR;
                        end
                    end
                    ERR: begin
                        if (bus.rx_data == CH_LF) begin
                            w_ack       = 1'b1;
                            w_ack_char  = CH_E;
                            w_state_nxt = IDLE;
                        end
                    end
                    default: w_state_nxt = IDLE;
                endcase
            end
        end

        // a fresh ack overrides both the pending one and a same-cycle handshake
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = r_tx_valid;
        if (w_ack) begin
            w_tx_data_nxt  = w_ack_char;
            w_tx_valid_nxt = 1'b1;
        end else if (r_tx_valid && bus.tx_ready) begin
            w_tx_valid_nxt = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_ndig     <= '0;
            r_cmd      <= '0;
            r_first    <= 1'b0;
            r_arg0     <= '0;
            r_base     <= '0;
            r_halt     <= 1'b0;
            r_start    <= 1'b0;
            r_step     <= 1'b0;
            r_crst     <= 1'b0;
            r_dvpage   <= '0;
            r_pvpage   <= '0;
            r_progen   <= 1'b0;
            r_progaddr <= '0;
            r_progdata <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_ndig     <= w_ndig_nxt;
            r_cmd      <= w_cmd_nxt;
            r_first    <= w_first_nxt;
            r_arg0     <= w_arg0_nxt;
            r_base     <= w_base_nxt;
            r_halt     <= w_halt_nxt;
            r_start    <= w_start_nxt;
            r_step     <= w_step_nxt;
            r_crst     <= w_crst_nxt;
            r_dvpage   <= w_dvpage_nxt;
            r_pvpage   <= w_pvpage_nxt;
            r_progen   <= w_progen_nxt;
            r_progaddr <= w_progaddr_nxt;
            r_progdata <= w_progdata_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
        end
    end

    assign bus.cpuhalt  = r_halt;
    assign bus.cpustart = r_start;
    assign bus.cpustep  = r_step;
    assign bus.cpurst   = r_crst;
    assign bus.dvpage   = r_dvpage;
    assign bus.pvpage   = r_pvpage;
    assign bus.progen   = r_progen;
    assign bus.progaddr = r_progaddr;
    assign bus.progdata = r_progdata;
    assign bus.tx_data  = r_tx_data;
    assign bus.tx_valid = r_tx_valid;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Purpose: self-checking bench for uart_cmd_parser: a table of whole packets
//          with expected ack, pages, pulse counts and program writes, plus
//          hand-written sequences for pulse timing, ack overwrite and reset.
module tb_uart_cmd_parser;

    localparam int unsigned DVPBITS = 8;
    localparam int unsigned PVPBITS = 8;
    localparam int unsigned WORDW   = 32;
    localparam int unsigned ADDRW   = 20;

    logic clk;
    logic rst;

    uart_cmd_parser_if #(.DVPBITS(DVPBITS), .PVPBITS(PVPBITS),
                         .WORDW(WORDW), .ADDRW(ADDRW)) bus ();

    uart_cmd_parser #(.DVPBITS(DVPBITS), .PVPBITS(PVPBITS),
                      .WORDW(WORDW), .ADDRW(ADDRW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       pkt;
        byte         ack;     // 0 = no ack expected
        logic [7:0]  dv;
        logic [7:0]  pv;
        int          nh;
        int          ns;
        int          nst;
        int          nr;
        int          nw;
        logic [19:0] wa0;
        logic [31:0] wd0;
        logic [19:0] wa1;
        logic [31:0] wd1;
    } vec_t;

    vec_t vq[$];

    int checks = 0;
    int errors = 0;

    // pulse / write monitor, sampled on the falling edge
    int          n_halt = 0, n_start = 0, n_step = 0, n_rst = 0, wr_cnt = 0;
    logic [19:0] wa_log[64];
    logic [31:0] wd_log[64];

    always @(negedge clk) begin
        if (bus.cpuhalt)  n_halt  <= n_halt + 1;
        if (bus.cpustart) n_start <= n_start + 1;
        if (bus.cpustep)  n_step  <= n_step + 1;
        if (bus.cpurst)   n_rst   <= n_rst + 1;
        if (bus.progen) begin
            wa_log[wr_cnt % 64] <= bus.progaddr;
            wd_log[wr_cnt % 64] <= bus.progdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // presents one byte for exactly one rising edge
    task automatic send_byte(input byte b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic add_vec(input string pkt, input byte ack, input logic [7:0] dv,
                           input logic [7:0] pv, input int nh, input int ns,
                           input int nst, input int nr, input int nw,
                           input logic [19:0] wa0, input logic [31:0] wd0,
                           input logic [19:0] wa1, input logic [31:0] wd1);
        vec_t v;
        v.pkt = pkt; v.ack = ack; v.dv = dv; v.pv = pv;
        v.nh = nh; v.ns = ns; v.nst = nst; v.nr = nr; v.nw = nw;
        v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        vq.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int h0, s0, st0, r0, w0;

        //        packet                          ack  dv     pv     H  Z  S  R  nw  wa0       wd0           wa1       wd1
        add_vec("S\n",                          "K", 8'h00, 8'h00, 0, 0, 1, 0, 0, 20'h0,    32'h0,        20'h0,    32'h0);
        add_vec("V1f,03\015\n",                 "K", 8'h1F, 8'h03, 0, 0, 0, 0, 0, 20'h0,    32'h0,        20'h0,    32'h0);
        add_vec("V,3\n",                        "E", 8'h1F, 8'h03, 0, 0, 0, 0, 0, 20'h0,    32'h0,        20'h0,    32'h0);
        add_vec("A00010\n",                     "K", 8'h1F, 8'h03, 0, 0, 0, 0, 0, 20'h0,    32'h0,        20'h0,    32'h0);
        add_vec("P[DEADBEEF,1]\n",              "K", 8'h1F, 8'h03, 1, 0, 0, 0, 2, 20'h00010, 32'hDEADBEEF, 20'h00011, 32'h1);
        add_vec("P[123456789]\n",               "E", 8'h1F, 8'h03, 1, 0, 0, 0, 0, 20'h0,    32'h0,        20'h0,    32'h0);
        add_vec("H\n",                          "K", 8'h1F, 8'h03, 1, 0, 0, 0, 0, 20'h0,    32'h0,        20'h0,    32'h0);
        add_vec("A FFFFF\n",                    "E", 8'h1F, 8'h03, 0, 0, 0, 0, 0, 20'h0,    32'h0,        20'h0,    32'h0);
        add_vec("AFFFFF\n",                     "K", 8'h1F, 8'h03, 0, 0, 0, 0, 0, 20'h0,    32'h0,        20'h0,    32'h0);
        add_vec("P[1,2]\n",                     "K", 8'h1F, 8'h03, 1, 0, 0, 0, 2, 20'hFFFFF, 32'h1,       20'h00000, 32'h2);
        add_vec("\n",                           0,   8'h1F, 8'h03, 0, 0, 0, 0, 0, 20'h0,    32'h0,        20'h0,    32'h0);
        add_vec("P[]\n",                        "K", 8'h1F, 8'h03, 1, 0, 0, 0, 0, 20'h0,    32'h0,        20'h0,    32'h0);
        add_vec("P[5,]\n",                      "E", 8'h1F, 8'h03, 1, 0, 0, 0, 1, 20'hFFFFF, 32'h5,       20'h0,    32'h0);
        add_vec("R\n",                          "K", 8'h1F, 8'h03, 0, 0, 0, 1, 0, 20'h0,    32'h0,        20'h0,    32'h0);
        add_vec("Z\015\n",                      "K", 8'h1F, 8'h03, 0, 1, 0, 0, 0, 20'h0,    32'h0,        20'h0,    32'h0);
        add_vec("Hx\n",                         "E", 8'h1F, 8'h03, 0, 0, 0, 0, 0, 20'h0,    32'h0,        20'h0,    32'h0);
        add_vec("V12345678,9abcdef0\n",         "K", 8'h78, 8'hF0, 0, 0, 0, 0, 0, 20'h0,    32'h0,        20'h0,    32'h0);
        add_vec("Q\n",                          "E", 8'h78, 8'hF0, 0, 0, 0, 0, 0, 20'h0,    32'h0,        20'h0,    32'h0);
        add_vec("Vg\n",                         "E", 8'h78, 8'hF0, 0, 0, 0, 0, 0, 20'h0,    32'h0,        20'h0,    32'h0);
        add_vec("V1\n",                         "E", 8'h78, 8'hF0, 0, 0, 0, 0, 0, 20'h0,    32'h0,        20'h0,    32'h0);
        add_vec("P[7]\n",                       "K", 8'h78, 8'hF0, 1, 0, 0, 0, 1, 20'hFFFFF, 32'h7,       20'h0,    32'h0);

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("reset_tx_data",  64'(bus.tx_data),  64'd0);
        chk("reset_pulses",   64'({bus.cpuhalt, bus.cpustart, bus.cpustep, bus.cpurst, bus.progen}), 64'd0);
        chk("reset_pages",    64'({bus.dvpage, bus.pvpage}), 64'd0);
        chk("reset_progaddr", 64'(bus.progaddr), 64'd0);
        chk("reset_progdata", 64'(bus.progdata), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < vq.size(); i++) begin
            h0 = n_halt; s0 = n_start; st0 = n_step; r0 = n_rst; w0 = wr_cnt;
            send_str(vq[i].pkt);
            if (vq[i].ack != 0) begin
                chk($sformatf("v%0d_tx_valid", i), 64'(bus.tx_valid), 64'd1);
                chk($sformatf("v%0d_tx_data", i),  64'(bus.tx_data),  64'(vq[i].ack));
                bus.tx_ready = 1'b1;
                tick();
                bus.tx_ready = 1'b0;
                chk($sformatf("v%0d_tx_clear", i), 64'(bus.tx_valid), 64'd0);
            end else begin
                tick();
                chk($sformatf("v%0d_no_ack", i), 64'(bus.tx_valid), 64'd0);
            end
            chk($sformatf("v%0d_dvpage", i), 64'(bus.dvpage), 64'(vq[i].dv));
            chk($sformatf("v%0d_pvpage", i), 64'(bus.pvpage), 64'(vq[i].pv));
            chk($sformatf("v%0d_halts", i),  64'(n_halt - h0),   64'(vq[i].nh));
            chk($sformatf("v%0d_starts", i), 64'(n_start - s0),  64'(vq[i].ns));
            chk($sformatf("v%0d_steps", i),  64'(n_step - st0),  64'(vq[i].nst));
            chk($sformatf("v%0d_rsts", i),   64'(n_rst - r0),    64'(vq[i].nr));
            chk($sformatf("v%0d_writes", i), 64'(wr_cnt - w0),   64'(vq[i].nw));
            if (vq[i].nw >= 1 && wr_cnt - w0 >= 1) begin
                chk($sformatf("v%0d_wa0", i), 64'(wa_log[w0 % 64]), 64'(vq[i].wa0));
                chk($sformatf("v%0d_wd0", i), 64'(wd_log[w0 % 64]), 64'(vq[i].wd0));
            end
            if (vq[i].nw >= 2 && wr_cnt - w0 >= 2) begin
                chk($sformatf("v%0d_wa1", i), 64'(wa_log[(w0 + 1) % 64]), 64'(vq[i].wa1));
                chk($sformatf("v%0d_wd1", i), 64'(wd_log[(w0 + 1) % 64]), 64'(vq[i].wd1));
            end
        end

        // step pulse: exactly one cycle, right after the '\n' edge; ack holds
        send_str("S");
        chk("step_before_lf", 64'(bus.cpustep), 64'd0);
        send_str("\n");
        chk("step_pulse", 64'(bus.cpustep), 64'd1);
        chk("step_ack_valid", 64'(bus.tx_valid), 64'd1);
        chk("step_ack_data", 64'(bus.tx_data), 64'h4B);
        tick();
        chk("step_pulse_end", 64'(bus.cpustep), 64'd0);
        repeat (3) tick();
        chk("ack_hold_valid", 64'(bus.tx_valid), 64'd1);
        chk("ack_hold_data", 64'(bus.tx_data), 64'h4B);
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        chk("ack_hold_clear", 64'(bus.tx_valid), 64'd0);

        // ack overwrite while tx_ready is low, then ack coinciding with a handshake
        send_str("H\n");
        chk("ovw_first_data", 64'(bus.tx_data), 64'h4B);
        send_str("Q\n");
        chk("ovw_second_valid", 64'(bus.tx_valid), 64'd1);
        chk("ovw_second_data", 64'(bus.tx_data), 64'h45);
        send_str("Z");
        bus.tx_ready = 1'b1;
        send_str("\n");
        bus.tx_ready = 1'b0;
        chk("collide_valid", 64'(bus.tx_valid), 64'd1);
        chk("collide_data", 64'(bus.tx_data), 64'h4B);
        chk("collide_start", 64'(bus.cpustart), 64'd1);
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        chk("collide_clear", 64'(bus.tx_valid), 64'd0);

        // reset in the middle of a program packet, with an ack pending
        send_str("H\n");
        send_str("P[AB,");
        chk("mid_progen", 64'(bus.progen), 64'd1);
        chk("mid_progaddr", 64'(bus.progaddr), 64'hFFFFF);
        chk("mid_progdata", 64'(bus.progdata), 64'hAB);
        rst = 1'b1;
        #1;
        chk("async_progen", 64'(bus.progen), 64'd0);
        chk("async_progaddr", 64'(bus.progaddr), 64'd0);
        chk("async_progdata", 64'(bus.progdata), 64'd0);
        chk("async_pages", 64'({bus.dvpage, bus.pvpage}), 64'd0);
        chk("async_tx", 64'({bus.tx_valid, bus.tx_data}), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        h0 = n_start;
        send_str("Z\n");
        chk("post_rst_start", 64'(bus.cpustart), 64'd1);
        chk("post_rst_ack", 64'({bus.tx_valid, bus.tx_data}), 64'h14B);
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        w0 = wr_cnt;
        send_str("P[1]\n");
        tick();
        chk("post_rst_writes", 64'(wr_cnt - w0), 64'd1);
        if (wr_cnt - w0 >= 1)
            chk("post_rst_base", 64'(wa_log[w0 % 64]), 64'd0);
        chk("post_rst_ack2", 64'({bus.tx_valid, bus.tx_data}), 64'h14B);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Parametrised successor of the UART control decoder. Consumes a received-byte stream and decodes ASCII command packets into CPU control pulses, view-page registers and program-memory writes.
- New over the previous generation: variable-length hex arguments, configurable word/address widths, a settable program base address, CR tolerance, and a one-byte K/E acknowledge stream back to the UART transmitter.

Parameters:
- DVPBITS, 8, data view page register width.
- PVPBITS, 8, prog view page register width.
- WORDW, 32, program word width; multiple of 4; MAXDIG = WORDW/4 hex digits.
- ADDRW, 20, program address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- tx_data  out  8  acknowledge byte ('K' or 'E').
- tx_valid  out  1  ack pending.
- tx_ready  in  1  transmitter accepts tx_data when tx_valid && tx_ready.
- cpuhalt  out  1  one-cycle pulse.
- cpustart  out  1  one-cycle pulse.
- cpustep  out  1  one-cycle pulse.
- cpurst  out  1  one-cycle pulse.
- dvpage  out  DVPBITS  data view page.
- pvpage  out  PVPBITS  prog view page.
- progen  out  1  one-cycle program write strobe.
- progaddr  out  ADDRW  write address.
- progdata  out  WORDW  write data.

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, accumulator 0, base address 0. The current packet is abandoned with no ack.
- Clock: one clock domain. All outputs are registered and take effect the cycle after the rx_valid that causes them.
- Byte filtering: bytes with rx_valid=0 are ignored. '\r' is ignored in every state.
- Hex parsing: accepts 0-9, A-F, a-f.
  - Accumulator: acc <= {acc, digit} (shift left by 4), truncated to WORDW.
  - Each argument needs at least 1 digit; the (MAXDIG+1)th digit is an error.
  - V arguments are truncated to DVPBITS/PVPBITS; A argument to ADDRW.
- Commands (first byte in IDLE):
  - H, Z, S, R: expect '\n', then pulse cpuhalt / cpustart / cpustep / cpurst.
  - V<hex>,<hex>\n: on '\n', load dvpage and pvpage together.
  - A<hex>\n: on '\n', load base address.
  - P[<hex>,<hex>,...]\n:
    - On 'P', pulse cpuhalt and load progaddr <= base.
    - Each ',' or ']' that closes a non-empty word pulses progen with progdata = acc.
    - progaddr increments the cycle after each progen; wraps modulo 2^ADDRW.
    - "[]" is legal and produces zero writes.
    - An empty word after ',' or before ']' (other than "[]") is an error.
    - Words already written before an error stay written.
  - '\n' in IDLE: ignored, no ack.
- States: IDLE, END1 (expect '\n'), ARG0, ARG1, AARG, POPEN (expect '['), PWORD, PEND (expect '\n' after ']'), ERR.
- Errors: any unexpected byte, bad digit, or overflow goes to ERR. ERR discards bytes until '\n', then returns to IDLE and emits 'E'. A '\n' that is itself the unexpected byte also ends the packet with 'E'.
- Acknowledge: every packet terminated by '\n' (outside IDLE) emits 'K' on success or 'E' on error; tx_valid rises the cycle after '\n'.
  - tx_valid/tx_data hold until tx_ready.
  - A new ack while one is pending overwrites tx_data (latest wins); tx_valid stays 1.
  - The ack handshake never stalls parsing.
- Simultaneous events: rx input has no backpressure, so a byte arriving in the same cycle as a tx handshake is processed normally. The state machine accepts at most one byte per cycle.

Test Plan:
- "S\n" -> cpustep=1 for exactly 1 cycle, one cycle after the '\n' strobe; then tx_data='K', tx_valid=1 until tx_ready.
- "V1f,03\r\n" -> dvpage=8'h1F, pvpage=8'h03, 'K'; "V,3\n" -> pages unchanged, 'E'.
- "A00010\n" then "P[DEADBEEF,1]\n" -> cpuhalt pulse; progen at addr 0x00010 data 32'hDEADBEEF, then at 0x00011 data 32'h00000001; 'K'.
- "P[123456789]\n" (9 digits, WORDW=32) -> no progen, 'E'; followed by "H\n" -> cpuhalt pulse, 'K'.
- "A FFFFF\n" (expected 'E' because of the space), then "AFFFFF\n", then "P[1,2]\n" -> writes at 0xFFFFF then 0x00000 (wrap).
- Assert rst mid-way through "P[AB," -> all outputs 0 immediately; next "Z\n" -> cpustart pulse, 'K'; tx_ready held low over two packets -> second ack overwrites the first.
